// File: rtl/lsu_pkg.sv
// Shared encodings for the RV32I load/store unit: funct3 codes, fault causes,
// FSM states and the byte-offset-to-lane mapping fixed by the data RAM.
package lsu_pkg;

    // RV32I load/store funct3 codes (stores use B/H/W only).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Response cause codes.
    localparam logic [1:0] CAUSE_OK       = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_RANGE    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    // The RAM places the byte at address offset 0 on the most significant lane.
    function automatic logic [1:0] lane_of(input logic [1:0] offset);
        return 2'd3 - offset;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_lane_steer.sv
// Combinational byte-lane steering between RV32I values and the RAM word:
// store side builds lane data and enables, load side extracts and extends.
module lsu_lane_steer
    import lsu_pkg::*;
(
    input  logic [31:0] st_value,
    input  logic [1:0]  st_offset,
    input  logic [1:0]  st_size,
    output logic [31:0] st_data,
    output logic [3:0]  st_wen,
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_funct3,
    output logic [31:0] ld_result
);

    logic [3:0] st_byte_en;
    logic [7:0] ld_bytes [4];

    // Which bytes of the store value are written: 1, 2 or 4 starting at byte 0.
    always_comb begin
        case (st_size)
            2'b00:   st_byte_en = 4'b0001;
            2'b01:   st_byte_en = 4'b0011;
            default: st_byte_en = 4'b1111;
        endcase
    end

    // Scatter value byte k onto the lane holding address offset+k; unused lanes stay 0.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        st_data = '0;
        st_wen  = '0;
        for (int k = 0; k < 4; k++) begin
            if (st_byte_en[k]) begin
                st_data[{lane_of(st_offset + 2'(k)), 3'b000} +: 8] = st_value[8*k +: 8];
                st_wen[lane_of(st_offset + 2'(k))]                 = 1'b1;
            end
        end
    end

    // Gather byte k of the loaded value from the lane holding address offset+k.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ld_bytes[k] = ld_word[{lane_of(ld_offset + 2'(k)), 3'b000} +: 8];
        end
    end

    // Sign- or zero-extend according to the load type.
    always_comb begin
        case (ld_funct3)
            F3_B:    ld_result = {{24{ld_bytes[0][7]}}, ld_bytes[0]};
            F3_H:    ld_result = {{16{ld_bytes[1][7]}}, ld_bytes[1], ld_bytes[0]};
            F3_W:    ld_result = {ld_bytes[3], ld_bytes[2], ld_bytes[1], ld_bytes[0]};
            F3_BU:   ld_result = {24'h0, ld_bytes[0]};
            F3_HU:   ld_result = {16'h0, ld_bytes[1], ld_bytes[0]};
            default: ld_result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit in front of a byte-enabled RAM with a 1-cycle
// registered read. One request in flight; faults answer without touching RAM.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int MemSize = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_wen_o,
    input  logic [31:0] mem_data_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [4:0]  rsp_rd_o,
    output logic [1:0]  rsp_cause_o
);

    state_e      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [3:0]  wen_q;
    logic        accept;
    logic        f3_legal;
    logic        misalign;
    logic        out_of_range;
    logic [1:0]  req_cause;
    logic [31:0] st_data;
    logic [3:0]  st_wen;
    logic [31:0] ld_result;

    assign req_ready_o = (state == S_IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    // Reset gates the enables immediately so a store caught mid-ACCESS never lands.
    assign mem_wen_o = wen_q & {4{~rst_i}};

    assign f3_legal = req_we_i
        ? (req_funct3_i inside {F3_B, F3_H, F3_W})
        : (req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign misalign = (((req_funct3_i == F3_H) || (req_funct3_i == F3_HU)) && req_addr_i[0])
                    || ((req_funct3_i == F3_W) && (req_addr_i[1:0] != 2'b00));
    assign out_of_range = req_addr_i >= 32'(MemSize);

    // Fault priority: illegal funct3, then misalignment, then range.
    always_comb begin
        if (!f3_legal)         req_cause = CAUSE_ILLEGAL;
        else if (misalign)     req_cause = CAUSE_MISALIGN;
        else if (out_of_range) req_cause = CAUSE_RANGE;
        else                   req_cause = CAUSE_OK;
    end

    // Store steering uses the live request; load extraction uses the latched one.
    lsu_lane_steer u_steer (
        .st_value  (req_wdata_i),
        .st_offset (req_addr_i[1:0]),
        .st_size   (req_funct3_i[1:0]),
        .st_data   (st_data),
        .st_wen    (st_wen),
        .ld_word   (mem_data_i),
        .ld_offset (mem_addr_o[1:0]),
        .ld_funct3 (funct3_q),
        .ld_result (ld_result)
    );

    // Request FSM with all outputs registered; rsp_valid_o is high only in RESP.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst_i) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            wen_q       <= '0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_rd_o    <= '0;
            rsp_cause_o <= CAUSE_OK;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q        <= req_we_i;
                        funct3_q    <= req_funct3_i;
                        mem_addr_o  <= req_addr_i;
                        rsp_rd_o    <= req_rd_i;
                        rsp_cause_o <= req_cause;
                        rsp_rdata_o <= '0;
                        if (req_cause != CAUSE_OK) begin
                            state       <= S_RESP;
                            rsp_valid_o <= 1'b1;
                        end else begin
                            state <= S_ACCESS;
                            if (req_we_i) begin
                                wen_q      <= st_wen;
                                mem_data_o <= st_data;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    wen_q <= '0;
                    if (we_q) begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    rsp_rdata_o <= ld_result;
                    rsp_valid_o <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: a lane-mapped RAM model on the
// memory port, and a byte-addressed reference memory that predicts results.
module tb_lsu_mem_stage;

    localparam int MemBytes = 1024;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_wen_o;
    logic [31:0] mem_data_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_rd_o;
    logic [1:0]  rsp_cause_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Physical RAM words as the DUT sees them, and the architectural byte view.
    logic [31:0] ram     [MemBytes/4] = '{default: '0};
    logic [7:0]  ref_mem [MemBytes]   = '{default: '0};

    lsu_mem_stage #(.MemSize(MemBytes)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_i     (req_rd_i),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_wen_o    (mem_wen_o),
        .mem_data_i   (mem_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_rd_o     (rsp_rd_o),
        .rsp_cause_o  (rsp_cause_o)
    );

    always #5 clk_i = ~clk_i;

    // Byte-enabled RAM with registered read.
    always @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_wen_o[l]) ram[mem_addr_o[9:2]][8*l +: 8] <= mem_data_o[8*l +: 8];
        end
        mem_data_i <= ram[mem_addr_o[9:2]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_cause(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit legal, half, word;
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        half = (f3 == 3'd1 || f3 == 3'd5);
        word = (f3 == 3'd2);
        if (!legal)                          return 2'b10;
        if ((half && a % 2 != 0) || (word && a % 4 != 0)) return 2'b01;
        if (a >= MemBytes)                   return 2'b11;
        return 2'b00;
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd2) return 4;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        int n;
        n = size_of(f3);
        v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[int'(a) + k]) << (8 * k));
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Expected RAM-side view of a store: byte k of the value sits on lane 3-((A+k)%4).
    task automatic exp_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v,
                             output logic [3:0] wen, output logic [31:0] data);
        int lane;
        logic [31:0] sh;
        wen  = '0;
        data = '0;
        for (int k = 0; k < size_of(f3); k++) begin
            lane = 3 - ((int'(a[1:0]) + k) % 4);
            wen[lane] = 1'b1;
            sh = v >> (8 * k);
            data = data | ({24'h0, sh[7:0]} << (8 * lane));
        end
    endtask

    // Issue one request, watch the ensuing cycles, compare against the model.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input bit hold,
                          output logic [31:0] got_rdata);
        logic [1:0]  ec;
        logic [3:0]  ew;
        logic [31:0] ed;
        logic [31:0] er;
        int lat, pulses, first, stray, budget;
        ec = exp_cause(we, f3, a);
        lat = (ec != 2'b00) ? 1 : (we ? 2 : 3);
        ew = '0;
        ed = '0;
        if (we && ec == 2'b00) exp_store(f3, a, wd, ew, ed);
        er = (!we && ec == 2'b00) ? exp_load(f3, a) : 32'h0;
        got_rdata = '0;

        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = wd;
        req_rd_i     = rd;
        req_valid_i  = 1'b1;
        budget = 0;
        while (!req_ready_o && budget < 20) begin
            @(negedge clk_i);
            budget++;
        end
        if (!req_ready_o) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        if (!hold) req_valid_i = 1'b0;

        pulses = 0;
        first  = 0;
        stray  = 0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk_i);
            if (k == 1) begin
                check("busy_ready", {31'h0, req_ready_o}, 32'd0);
                check("mem_addr", mem_addr_o, a);
                check("wen", {28'h0, mem_wen_o}, {28'h0, ew});
                if (ew != 4'h0) check("wdata", mem_data_o, ed);
            end else if (mem_wen_o != 4'h0) begin
                stray++;
            end
            if (rsp_valid_o) begin
                pulses++;
                if (first == 0) begin
                    first = k;
                    got_rdata = rsp_rdata_o;
                    check("rsp_cause", {30'h0, rsp_cause_o}, {30'h0, ec});
                    check("rsp_rd", {27'h0, rsp_rd_o}, {27'h0, rd});
                    check("rsp_rdata", rsp_rdata_o, er);
                end
            end
        end
        check("rsp_pulses", pulses, 1);
        check("rsp_latency", first, lat);
        check("stray_wen", stray, 0);
        check("ready_back", {31'h0, req_ready_o}, 32'd1);

        if (we && ec == 2'b00) begin
            for (int k = 0; k < size_of(f3); k++) ref_mem[int'(a) + k] = 8'(wd >> (8 * k));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        logic [2:0]  f3;
        logic [31:0] a;
        int sel;

        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = '0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_rd_i     = '0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'h0, req_ready_o}, 32'd0);
        check("rst_wen", {28'h0, mem_wen_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("init_ready", {31'h0, req_ready_o}, 32'd1);
        check("init_rsp_valid", {31'h0, rsp_valid_o}, 32'd0);
        check("init_mem_addr", mem_addr_o, 32'd0);
        check("init_rdata", rsp_rdata_o, 32'd0);
        check("init_cause", {30'h0, rsp_cause_o}, 32'd0);

        // Directed sequence with known answers.
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344, 5'd1, 1'b0, r);
        do_req(1'b1, 3'b000, 32'h13, 32'h000000AB, 5'd2, 1'b0, r);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd3, 1'b0, r);
        check("lw_plan", r, 32'hAB223344);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd4, 1'b0, r);
        check("lb_plan", r, 32'hFFFFFFAB);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd5, 1'b0, r);
        check("lbu_plan", r, 32'h000000AB);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd6, 1'b0, r);
        check("lh_plan", r, 32'hFFFFAB22);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 5'd7, 1'b0, r);
        check("lhu_plan", r, 32'h0000AB22);

        // Faults.
        do_req(1'b0, 3'b010, 32'h12,  32'h0, 5'd8,  1'b0, r);
        do_req(1'b0, 3'b011, 32'h10,  32'h0, 5'd9,  1'b0, r);
        do_req(1'b1, 3'b010, 32'h400, 32'h55, 5'd10, 1'b0, r);
        do_req(1'b1, 3'b111, 32'h12,  32'h55, 5'd11, 1'b0, r);
        do_req(1'b0, 3'b101, 32'h3FF, 32'h0, 5'd12, 1'b0, r);

        // Reset during a store's ACCESS cycle drops it completely.
        req_we_i     = 1'b1;
        req_funct3_i = 3'b010;
        req_addr_i   = 32'h40;
        req_wdata_i  = 32'hDEADBEEF;
        req_rd_i     = 5'd13;
        req_valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        rst_i       = 1'b1;
        @(negedge clk_i);
        check("rst_access_wen", {28'h0, mem_wen_o}, 32'd0);
        check("rst_access_ready", {31'h0, req_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sel = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o) sel++;
        end
        check("rst_no_rsp", sel, 0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_rsp_rd", {27'h0, rsp_rd_o}, 32'd0);
        check("rst_idle_ready", {31'h0, req_ready_o}, 32'd1);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 5'd14, 1'b0, r);
        check("rst_store_dropped", r, 32'h0);

        // Back-to-back with valid held high between requests.
        do_req(1'b1, 3'b010, 32'h80, 32'hCAFEF00D, 5'd15, 1'b1, r);
        do_req(1'b0, 3'b001, 32'h82, 32'h0,        5'd16, 1'b1, r);
        do_req(1'b0, 3'b011, 32'h80, 32'h0,        5'd17, 1'b1, r);
        do_req(1'b1, 3'b000, 32'h81, 32'h000000EE, 5'd18, 1'b1, r);
        do_req(1'b0, 3'b010, 32'h80, 32'h0,        5'd19, 1'b0, r);

        // Randomized traffic against the byte-level model.
        for (int i = 0; i < 300; i++) begin
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            a   = $urandom_range(0, MemBytes - 1);
            if (sel < 6) a = a & ~(32'(size_of(f3)) - 32'd1);
            else if (sel == 9) a = ($urandom_range(0, 1) != 0) ? 32'h400 + $urandom_range(0, 4095) : $urandom;
            do_req(1'($urandom_range(0, 1)), f3, a, $urandom, 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) && (i != 299), r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- RV32I load/store unit sitting directly upstream of the byte-enabled data RAM.
- Accepts one load/store request at a time from the pipeline and checks funct3, alignment and range.
- Drives the RAM's word address, byte-write enables and lane-steered store data.
- Waits out the RAM's 1-cycle registered read, then returns sign/zero-extended load data with a one-cycle response pulse.

Parameters:
- MemSize, 1024, RAM size in bytes, multiple of 4. Request addresses >= MemSize fault.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3 of the load/store.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store value from rs2.
- req_rd_i  in  5  destination register, carried through.
- mem_addr_o  out  32  RAM address (low 2 bits don't-care to RAM).
- mem_data_o  out  32  RAM write data.
- mem_wen_o  out  4  RAM lane write enables.
- mem_data_i  in  32  RAM read data, valid 1 cycle after the address is presented.
- rsp_valid_o  out  1  response pulse.
- rsp_rdata_o  out  32  extended load data (0 for stores/faults).
- rsp_rd_o  out  5  destination register.
- rsp_cause_o  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 out of range.

Behaviour:
- Lane map, fixed by the RAM:
  - Byte at address A sits on lane L = 3 - A[1:0], i.e. bits [8L+7:8L].
  - Byte k of a value (k=0 least significant) goes to address A+k.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other codes are illegal.
- Fault priority: illegal > misaligned (H: A[0]!=0; W: A[1:0]!=0) > out of range (A >= MemSize).
- FSM states: IDLE, ACCESS, WAIT, RESP. Registered state. Request fields latched on accept.
- IDLE:
  - req_ready_o = 1 (forced 0 while rst_i).
  - On req_valid_i & req_ready_o: latch request, evaluate faults.
  - Fault -> RESP with cause set and no RAM write. Else -> ACCESS.
- ACCESS:
  - mem_addr_o = latched address.
  - Store: mem_wen_o = lane mask, mem_data_o = steered bytes, disabled lanes 0; next RESP.
  - Load: mem_wen_o = 0; next WAIT.
- WAIT:
  - Extract bytes per lane map from mem_data_i.
  - Sign-extend LB/LH, zero-extend LBU/LHU, LW unchanged.
  - Register result into rsp_rdata_o; next RESP.
- RESP: rsp_valid_o = 1 for exactly one cycle; next IDLE.
- Outside ACCESS: mem_wen_o = 0. mem_addr_o holds the last latched address.
- Latency from accept edge T to rsp_valid_o high:
  - Fault: T+1.
  - Store: T+2.
  - Load: T+3.
- Throughput: one request per 2 (fault), 3 (store) or 4 (load) cycles. No back-pressure on response; the consumer must accept the pulse.
- Reset (any state, any cycle):
  - Next state IDLE.
  - mem_wen_o forced 0 combinationally during rst_i, so no partial store.
  - All registered outputs cleared: rsp_valid_o, rsp_rdata_o, rsp_rd_o, rsp_cause_o, mem_addr_o = 0.
  - An in-flight request is dropped with no response.
- req_valid_i while not ready is ignored. The requester holds it until ready.

Decomposition:
- lsu_pkg holds:
  - funct3 constants (F3_B/H/W/BU/HU).
  - cause codes (CAUSE_OK/MISALIGN/ILLEGAL/RANGE).
  - FSM state encoding.
  - a function mapping a byte offset to its lane.
- One combinational sub-module, lsu_lane_steer, is natural:
  - store path: value + offset + size -> mem_data_o / mem_wen_o.
  - load path: word + offset + funct3 -> extended result.
- The FSM stays in lsu_mem_stage.

Test Plan:
- SW addr 0x10 data 0x11223344 -> ACCESS cycle mem_wen_o=1111, mem_data_o=0x44332211. RESP at T+2, cause 00, rdata 0.
- SB addr 0x13 data 0x000000AB -> mem_wen_o=0001, mem_data_o=0x000000AB. Then LW 0x10 -> rsp_rdata_o=0xAB223344 at T+3.
- Following the above:
  - LB 0x13 -> 0xFFFFFFAB.
  - LBU 0x13 -> 0x000000AB.
  - LH 0x12 -> 0xFFFFAB22.
  - LHU 0x12 -> 0x0000AB22.
  - rd echoed.
- Faults, each with no wen pulse and response at T+1:
  - LW addr 0x12 -> cause 01.
  - funct3 011 load -> cause 10.
  - SW 0x400 (MemSize 1024) -> cause 11.
  - funct3 111 at 0x12 -> cause 10 (priority over misaligned).
- Store accepted, rst_i asserted in its ACCESS cycle -> mem_wen_o=0, no rsp_valid_o, state IDLE. Subsequent LW of that address returns 0.
- Back-to-back requests with req_valid_i held high -> req_ready_o low outside IDLE. Exactly one acceptance per request, responses in order.
